// File: rtl/eeprom_cmd_queue.sv
// Command front-end for the EEPROM byte controller: buffers host read/write
// requests in a FIFO and issues them one at a time over RD/WR/ADDR/DATA/ACK.
// Optional ACK timeout: define EEPROM_CMDQ_TIMEOUT_EN.

module eeprom_cmd_queue #(
  parameter int DEPTH       = 4,
  parameter int AW          = 11,
  parameter int DW          = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_rw,
  input  logic [AW-1:0]          cmd_addr,
  input  logic [DW-1:0]          cmd_wdata,
  output logic                   rsp_valid,
  output logic [DW-1:0]          rsp_rdata,
  output logic [AW-1:0]          rsp_addr,
  output logic                   wr_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   RD,
  output logic                   WR,
  output logic [AW-1:0]          ADDR,
  inout  wire  [DW-1:0]          DATA,
  input  logic                   ACK,
  output logic                   err
);

  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
    $error("eeprom_cmd_queue: DEPTH must be a power of 2 in 2..16, TIMEOUT_CYC in 1..65535");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_e;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } entry_t;

  // ---------------------------------------------------------------- FIFO
  entry_t      mem_q [DEPTH];
  entry_t      head;
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic        full, empty, push, pop;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign level     = wr_ptr_q - rd_ptr_q;
  assign head      = mem_q[rd_ptr_q[PW-1:0]];
  assign wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // NOTE: storage array is deliberately not reset; the pointers alone define
  // which entries are valid, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};
  end

  // ------------------------------------------------------------ requester
  state_e        state_q, state_d;
  logic          rd_q, rd_d, wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [AW-1:0] rsp_addr_q, rsp_addr_d;
  logic          wr_done_q, wr_done_d;
`ifdef EEPROM_CMDQ_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_addr_d  = rsp_addr_q;
    wr_done_d   = 1'b0;
    pop         = 1'b0;
`ifdef EEPROM_CMDQ_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          addr_d  = head.addr;
          wdata_d = head.wdata;
          rd_d    = head.rw;
          wr_d    = !head.rw;
          state_d = ST_ISSUE;
`ifdef EEPROM_CMDQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_ISSUE: begin
        if (ACK) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_GAP;
          if (rd_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = DATA;
            rsp_addr_d  = addr_q;
          end else begin
            wr_done_d = 1'b1;
          end
        end
`ifdef EEPROM_CMDQ_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          // Controller never answered: abandon the command and keep draining.
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= ST_IDLE;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_addr_q  <= '0;
      wr_done_q   <= 1'b0;
`ifdef EEPROM_CMDQ_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_addr_q  <= rsp_addr_d;
      wr_done_q   <= wr_done_d;
`ifdef EEPROM_CMDQ_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign RD        = rd_q;
  assign WR        = wr_q;
  assign ADDR      = addr_q;
  assign DATA      = wr_q ? wdata_q : {DW{1'bz}};
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_addr  = rsp_addr_q;
  assign wr_done   = wr_done_q;
  assign busy      = !empty || (state_q != ST_IDLE);
`ifdef EEPROM_CMDQ_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_eeprom_cmd_queue.sv
// Self-checking bench for eeprom_cmd_queue: random host traffic, an EEPROM
// controller model on the bus side, and an in-order scoreboard of responses.

module tb_eeprom_cmd_queue;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [10:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, wr_done, busy, RD, WR, ACK, err;
  logic [7:0]  rsp_rdata;
  logic [10:0] rsp_addr, ADDR;
  logic [2:0]  level;
  wire  [7:0]  DATA;

  logic        drv;
  logic [7:0]  drv_val;
  assign DATA = drv ? drv_val : 8'hzz;

  always #5 CLK = ~CLK;

  eeprom_cmd_queue #(.DEPTH(4), .AW(11), .DW(8), .TIMEOUT_CYC(65535)) dut (
    .CLK(CLK), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
    .wr_done(wr_done), .busy(busy), .level(level),
    .RD(RD), .WR(WR), .ADDR(ADDR), .DATA(DATA), .ACK(ACK), .err(err)
  );

  typedef struct {
    bit          rw;
    logic [10:0] addr;
    logic [7:0]  data;
  } txn_t;

  txn_t       iss_q[$];   // bus requests expected, in order
  txn_t       exp_q[$];   // host responses expected, in order
  logic [7:0] ref_mem [2048];
  logic [7:0] dev_mem [2048];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, accepted = 0, issued = 0, err_cnt = 0;
  int ack_cyc = -100, last_gap = -1;
  int fixed_delay = -1, wait_cnt = 0;
  bit stall = 0, spurious_en = 0, in_txn = 0, pending_at_ack = 0;
  logic [10:0] hold_addr;
  logic [7:0]  hold_data;

  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (err) err_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [10:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // EEPROM byte controller model
  initial begin
    ACK = 1'b0; drv = 1'b0; drv_val = '0;
    forever begin
      @(negedge CLK);
      if (RD || WR) check("rd_wr_exclusive", 32'(RD & WR), 0);
      if (RD && !drv) check("data_z_while_rd", 32'(DATA === 8'hzz), 1);
      ACK = 1'b0;
      drv = 1'b0;
      if (!RD && !WR) begin
        in_txn = 0;
        if (spurious_en && $urandom_range(0, 3) == 0) ACK = 1'b1;
      end else begin
        if (!in_txn) begin
          txn_t e;
          in_txn = 1;
          issued++;
          last_gap = cyc - ack_cyc;
          if (pending_at_ack) check("rise_3_after_ack", last_gap, 3);
          else check("rise_gap_min3", 32'(last_gap >= 3), 1);
          if (iss_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_issue: RD=%0b WR=%0b ADDR=0x%0h, expected none", RD, WR, ADDR);
          end else begin
            e = iss_q.pop_front();
            check("issue_rd", RD, e.rw);
            check("issue_addr", ADDR, e.addr);
            if (!e.rw) check("issue_wdata", DATA, e.data);
          end
          hold_addr = ADDR;
          hold_data = DATA;
          if (fixed_delay >= 0) wait_cnt = fixed_delay;
          else if ($urandom_range(0, 7) == 0) wait_cnt = $urandom_range(8, 40);
          else wait_cnt = $urandom_range(0, 3);
        end else begin
          check("addr_stable", ADDR, hold_addr);
          if (WR) check("wdata_stable", DATA, hold_data);
        end
        if (!stall) begin
          if (wait_cnt == 0) begin
            ACK = 1'b1;
            ack_cyc = cyc;
            pending_at_ack = (accepted - issued) > 0;
            if (WR) dev_mem[ADDR] = DATA;
            else begin drv = 1'b1; drv_val = dev_mem[ADDR]; end
          end else begin
            wait_cnt--;
          end
        end
      end
    end
  end

  // Response monitor / scoreboard
  initial begin
    forever begin
      @(negedge CLK);
      if (rsp_valid || wr_done) begin
        check("rsp_wrdone_exclusive", 32'(rsp_valid & wr_done), 0);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_response: rsp_valid=%0b wr_done=%0b, expected none", rsp_valid, wr_done);
        end else begin
          txn_t e;
          e = exp_q.pop_front();
          check("rsp_kind", rsp_valid, e.rw);
          if (e.rw) begin
            check("rsp_rdata", rsp_rdata, e.data);
            check("rsp_addr", rsp_addr, e.addr);
          end
        end
      end
    end
  end

  // Host push; called just after a rising edge, returns just after the accepting edge.
  task automatic push(input bit rw, input logic [10:0] a, input logic [7:0] d);
    bit rdy = 0;
    int n = 0;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
    do begin
      @(negedge CLK); rdy = cmd_ready;
      @(posedge CLK); n++;
    end while (!rdy && n < 5000);
    if (!rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout: cmd_ready stayed 0 for %0d cycles, expected acceptance", n);
    end else begin
      accepted++;
      if (!rw) ref_mem[a] = d;
      iss_q.push_back('{rw: rw, addr: a, data: d});
      exp_q.push_back('{rw: rw, addr: a, data: rw ? ref_mem[a] : d});
    end
    #1;
    cmd_valid = 1'b0; cmd_rw = 1'($urandom); cmd_addr = 11'($urandom); cmd_wdata = 8'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 5000) begin
      @(negedge CLK); n++;
    end
    check({name, "_busy"}, busy, 0);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ref_mem[i] = init_byte(11'(i));
      dev_mem[i] = init_byte(11'(i));
    end
    RESET = 1'b0;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 11'h7FF; cmd_wdata = 8'hFF;

    // reset held with a request pending
    repeat (3) @(negedge CLK);
    check("rst_rd", RD, 0);
    check("rst_wr", WR, 0);
    check("rst_data_z", 32'(DATA === 8'hzz), 1);
    check("rst_level", level, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_wr_done", wr_done, 0);
    check("rst_err", err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_addr", rsp_addr, 0);
    check("rst_addr", ADDR, 0);
    cmd_valid = 1'b0;
    @(posedge CLK); #1 RESET = 1'b1;
    repeat (10) @(negedge CLK);
    check("idle_after_reset_busy", busy, 0);
    check("idle_after_reset_level", level, 0);
    @(posedge CLK); #1;

    // single write with a slow controller
    fixed_delay = 200;
    push(1'b0, 11'h0A5, 8'h3C);
    wait_idle("single_write");
    @(posedge CLK); #1;

    // single read of the top address (EEPROM holds A5 there)
    fixed_delay = 2;
    push(1'b1, 11'h7FF, 8'h00);
    wait_idle("single_read");
    @(posedge CLK); #1;

    // fill / overflow with ACK stalled
    stall = 1; fixed_delay = 0;
    push(1'b0, 11'h010, 8'h11);
    push(1'b1, 11'h010, 8'h00);
    push(1'b0, 11'h020, 8'h22);
    push(1'b1, 11'h020, 8'h00);
    push(1'b0, 11'h030, 8'h33);
    fork
      push(1'b1, 11'h030, 8'h00);
      begin
        repeat (3) @(negedge CLK);
        check("fill_level", level, 4);
        check("fill_cmd_ready", cmd_ready, 0);
        check("fill_sixth_held", accepted, 7);
        stall = 0;
      end
    join
    wait_idle("fill_drain");
    @(posedge CLK); #1;

    // write then read of the same address, back to back
    fixed_delay = 3;
    push(1'b0, 11'h123, 8'h5A);
    push(1'b1, 11'h123, 8'h00);
    wait_idle("wr_rd");
    check("wr_rd_gap", last_gap, 3);
    @(posedge CLK); #1;

    // randomized traffic with spurious ACKs between transactions
    fixed_delay = -1; spurious_en = 1;
    for (int i = 0; i < 80; i++) begin
      logic [10:0] a;
      case ($urandom_range(0, 9))
        0:       a = 11'h000;
        1:       a = 11'h7FF;
        default: a = 11'($urandom_range(0, 7)) << 4;
      endcase
      push(1'($urandom), a, 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) @(posedge CLK);
        #1;
      end
    end
    wait_idle("random_drain");
    spurious_en = 0;
    check("random_level", level, 0);
    check("no_err_pulses", err_cnt, 0);
    @(posedge CLK); #1;

    // reset mid-transaction drops the request
    stall = 1;
    push(1'b0, 11'h055, 8'h77);
    begin
      int n = 0;
      while (!WR && n < 100) begin @(negedge CLK); n++; end
    end
    check("mid_wr_seen", WR, 1);
    @(posedge CLK); #3 RESET = 1'b0;
    #1;
    check("mid_rst_wr", WR, 0);
    check("mid_rst_rd", RD, 0);
    check("mid_rst_data_z", 32'(DATA === 8'hzz), 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_level", level, 0);
    exp_q.delete();
    iss_q.delete();
    stall = 0;
    @(posedge CLK); #1 RESET = 1'b1;
    repeat (5) @(negedge CLK);
    check("post_rst_busy", busy, 0);
    check("post_rst_wr", WR, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
